alu_issue_seq: RTL

- Single-issue sequencer on the driving side of the 128-bit SPU ALU. It accepts decoded instructions over a valid/ready handshake and reads operands from a local 128-bit register file.
- It drives the ALU operand and control ports (a, b, c, ALUctr), captures out/zero_signal, and writes the result back.
- It sits between the instruction decode stage and the combinational ALU, and provides the only sequencing/writeback path for ALU ops.

---
 rtl/spu_alu_pkg.sv | 33 +++
 rtl/spu_regfile.sv | 40 ++++
 rtl/alu_issue_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/spu_alu_pkg.sv
// rtl/spu_alu_pkg.sv - shared types and helpers for the SPU ALU issue sequencer
package spu_alu_pkg;

   localparam int DATA_W = 128;

   typedef enum logic [3:0] {
      ALU_SUB  = 4'd0,
      ALU_ADD  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SHL  = 4'd5,
      ALU_SHR  = 4'd6,
      ALU_MUL  = 4'd7,
      ALU_EQ   = 4'd8,
      ALU_PASS = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } seq_state_e;

   function automatic logic is_legal_op(input logic [3:0] op);
      case (op)
         ALU_SUB, ALU_ADD, ALU_AND, ALU_OR, ALU_XOR,
         ALU_SHL, ALU_SHR, ALU_MUL, ALU_EQ, ALU_PASS: return 1'b1;
         default:                                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/spu_regfile.sv
// rtl/spu_regfile.sv - NREGS x 128 register file, three async reads, two prioritised writes
module spu_regfile
   import spu_alu_pkg::*;
#(
   parameter int  NREGS = 16,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     rd0_addr_i,
   input  logic [AW-1:0]     rd1_addr_i,
   input  logic [AW-1:0]     rd2_addr_i,
   output logic [DATA_W-1:0] rd0_data_o,
   output logic [DATA_W-1:0] rd1_data_o,
   output logic [DATA_W-1:0] rd2_data_o,
   input  logic              we0_i,
   input  logic [AW-1:0]     wa0_i,
   input  logic [DATA_W-1:0] wd0_i,
   input  logic              we1_i,
   input  logic [AW-1:0]     wa1_i,
   input  logic [DATA_W-1:0] wd1_i
);

   logic [DATA_W-1:0] mem_q [NREGS];

   assign rd0_data_o = mem_q[rd0_addr_i];
   assign rd1_data_o = mem_q[rd1_addr_i];
   assign rd2_data_o = mem_q[rd2_addr_i];

   // Port 0 is issued last so it overrides port 1 on an address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
      end else begin
         if (we1_i) mem_q[wa1_i] <= wd1_i;
         if (we0_i) mem_q[wa0_i] <= wd0_i;
      end
   end

endmodule

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - single-issue sequencer driving the 128-bit SPU ALU
module alu_issue_seq
   import spu_alu_pkg::*;
#(
   parameter int  NREGS      = 16,
   parameter int  MUL_CYCLES = 2,
   localparam int AW         = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [AW-1:0]     in_ra,
   input  logic [AW-1:0]     in_rb,
   input  logic [AW-1:0]     in_rc,
   input  logic [AW-1:0]     in_rt,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [DATA_W-1:0] alu_c,
   output logic [3:0]        alu_ctr,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_zero,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              err
);

   localparam int CW = (MUL_CYCLES > 0) ? $clog2(MUL_CYCLES + 1) : 1;

   seq_state_e        state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, res_q, res_d;
   logic [3:0]        ctr_q, ctr_d;
   logic [AW-1:0]     dest_q, dest_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              zero_q, zero_d, err_q, err_d;
   logic [DATA_W-1:0] rd_a, rd_b, rd_c;
   logic              wb_we;

   assign wb_we = (state_q == WB) && !err_q;

   spu_regfile #(.NREGS(NREGS)) u_rf (
      .clk        (clk),
      .rst        (rst),
      .rd0_addr_i (in_ra),
      .rd1_addr_i (in_rb),
      .rd2_addr_i (in_rc),
      .rd0_data_o (rd_a),
      .rd1_data_o (rd_b),
      .rd2_data_o (rd_c),
      .we0_i      (wb_we),
      .wa0_i      (dest_q),
      .wd0_i      (res_q),
      .we1_i      (wr_en),
      .wa1_i      (wr_addr),
      .wd1_i      (wr_data)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      ctr_d   = ctr_q;
      dest_d  = dest_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      zero_d  = zero_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (is_legal_op(in_op)) begin
                  a_d     = rd_a;
                  b_d     = rd_b;
                  c_d     = rd_c;
                  ctr_d   = in_op;
                  dest_d  = in_rt;
                  cnt_d   = (in_op == ALU_MUL) ? CW'(MUL_CYCLES) : '0;
                  err_d   = 1'b0;
                  state_d = EXEC;
               end else begin
                  // Illegal ops leave the ALU ports untouched and skip writeback.
                  err_d   = 1'b1;
                  state_d = WB;
               end
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               res_d   = alu_out;
               zero_d  = alu_zero;
               state_d = WB;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         ctr_q   <= ALU_PASS;
         dest_q  <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         ctr_q   <= ctr_d;
         dest_q  <= dest_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         err_q   <= err_d;
      end
   end

   assign in_ready = (state_q == IDLE);
   assign done     = (state_q == WB);
   assign err      = (state_q == WB) && err_q;
   assign zero     = zero_q;
   assign result   = res_q;
   assign alu_a    = a_q;
   assign alu_b    = b_q;
   assign alu_c    = c_q;
   assign alu_ctr  = ctr_q;

endmodule
